exp_lut_arbiter: RTL and testbench

- Shares one fixed-latency exponential LUT read port between NUM_REQ independent requesters, e.g. quote and skew engines.
- Round-robin arbitration with a valid/ready request handshake.
- Clamps each request to the LUT domain [-1.0, +1.0] in q32.32.
- Tags each issued lookup and routes the LUT result back to its requester, with a saturation flag.
- Sits between the strategy/pricing engines and the LUT instance.

---
 rtl/exp_lut_arbiter.sv | 135 +++++++++++++
 tb/tb_exp_lut_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_lut_arbiter.sv
// Round-robin arbiter sharing one fixed-latency exp LUT port between NUM_REQ requesters.
// Clamps operands to [-1.0, +1.0] q32.32 and routes tagged results back with a saturation flag.
module exp_lut_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned LUT_LATENCY = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*64-1:0]     i_req_value,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_lut_valid,
    output logic [63:0]               o_lut_value,
    input  logic [63:0]               i_lut_result,
    output logic [NUM_REQ-1:0]        o_resp_valid,
    output logic [63:0]               o_resp_value,
    output logic                      o_resp_sat,
    output logic                      o_idle,
    output logic [15:0]               o_sat_count
);

    localparam int unsigned IDW  = $clog2(NUM_REQ);
    localparam int unsigned DW   = 64;
    localparam int unsigned TAGS = LUT_LATENCY + 1;

    localparam logic signed [DW-1:0] POS_ONE = 64'sh0000_0001_0000_0000;
    localparam logic signed [DW-1:0] NEG_ONE = 64'shFFFF_FFFF_0000_0000;
    localparam logic [15:0]          SAT_MAX = 16'hFFFF;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           sat;
    } tag_t;

    logic [NUM_REQ-1:0]   busy_q;
    logic [NUM_REQ-1:0]   busy_nxt;
    logic [NUM_REQ-1:0]   elig_c;
    logic [NUM_REQ-1:0]   resp_onehot_c;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       ptr_nxt;
    logic [IDW-1:0]       win_idx;
    logic [IDW-1:0]       cand_idx;
    logic                 win_found;
    logic signed [DW-1:0] req_sel;
    logic [DW-1:0]        clamp_val;
    logic                 clamp_sat;
    tag_t [TAGS-1:0]      tag_q;
    tag_t                 tag_in;
    tag_t                 tag_out;

    // Round-robin search from ptr; ready is combinational on the winner
    always_comb begin
        elig_c      = i_req_valid & ~busy_q & {NUM_REQ{i_enable & i_rst_n}};
        win_found   = 1'b0;
        win_idx     = '0;
        cand_idx    = '0;
        o_req_ready = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDW'((32'(ptr_q) + k) % NUM_REQ);
            if (!win_found && elig_c[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        if (win_found) begin
            o_req_ready[win_idx] = 1'b1;
        end
        ptr_nxt = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
    end

    // Clamp the winning operand into the LUT domain
    always_comb begin
        req_sel   = i_req_value[{win_idx, 6'd0} +: DW];
        clamp_val = req_sel;
        clamp_sat = 1'b0;
        if (req_sel > POS_ONE) begin
            clamp_val = POS_ONE;
            clamp_sat = 1'b1;
        end else if (req_sel < NEG_ONE) begin
            clamp_val = NEG_ONE;
            clamp_sat = 1'b1;
        end
    end

    // Tag at the end of the pipe lines up with i_lut_result
    always_comb begin
        tag_in.valid  = win_found;
        tag_in.id     = win_idx;
        tag_in.sat    = clamp_sat;
        tag_out       = tag_q[TAGS-1];
        resp_onehot_c = '0;
        if (tag_out.valid) begin
            resp_onehot_c[tag_out.id] = 1'b1;
        end
        busy_nxt = busy_q & ~resp_onehot_c;
        if (win_found) begin
            busy_nxt[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q       <= '0;
            ptr_q        <= '0;
            tag_q        <= '0;
            o_idle       <= 1'b1;
            o_lut_valid  <= 1'b0;
            o_lut_value  <= '0;
            o_resp_valid <= '0;
            o_resp_value <= '0;
            o_resp_sat   <= 1'b0;
            o_sat_count  <= '0;
        end else begin
            busy_q       <= busy_nxt;
            o_idle       <= ~|busy_nxt;
            tag_q        <= {tag_q[TAGS-2:0], tag_in};
            o_lut_valid  <= win_found;
            o_resp_valid <= resp_onehot_c;
            if (win_found) begin
                ptr_q       <= ptr_nxt;
                o_lut_value <= clamp_val;
                if (clamp_sat && (o_sat_count != SAT_MAX)) begin
                    o_sat_count <= o_sat_count + 16'd1;
                end
            end
            if (tag_out.valid) begin
                o_resp_value <= i_lut_result;
                o_resp_sat   <= tag_out.sat;
            end
        end
    end

endmodule

// File: tb/tb_exp_lut_arbiter.sv
// Bench for exp_lut_arbiter: transaction-level model with per-cycle compare plus directed literal checks.
module tb_exp_lut_arbiter;

    localparam int N   = 4;
    localparam int LAT = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req_valid;
    logic [N*64-1:0]  req_value;
    logic [N-1:0]     req_ready;
    logic             lut_valid;
    logic [63:0]      lut_value;
    logic [63:0]      lut_result;
    logic [N-1:0]     resp_valid;
    logic [63:0]      resp_value;
    logic             resp_sat;
    logic             idle;
    logic [15:0]      sat_count;

    int n_pass = 0;
    int n_total = 0;

    exp_lut_arbiter #(.NUM_REQ(N), .LUT_LATENCY(LAT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (en),
        .i_req_valid  (req_valid),
        .i_req_value  (req_value),
        .o_req_ready  (req_ready),
        .o_lut_valid  (lut_valid),
        .o_lut_value  (lut_value),
        .i_lut_result (lut_result),
        .o_resp_valid (resp_valid),
        .o_resp_value (resp_value),
        .o_resp_sat   (resp_sat),
        .o_idle       (idle),
        .o_sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lut_f(input logic [63:0] v);
        return v * 64'd3 + 64'h0000_1234_5678_9abc;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [63:0] v);
        req_value[64*idx +: 64] = v;
    endtask

    // LUT model: result for an issued operand appears LAT cycles later, noise otherwise
    logic        lv_pipe  [LAT];
    logic [63:0] lval_pipe[LAT];
    always @(negedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            lv_pipe[i]   = lv_pipe[i-1];
            lval_pipe[i] = lval_pipe[i-1];
        end
        lv_pipe[0]   = lut_valid;
        lval_pipe[0] = lut_value;
    end
    always @(posedge clk) begin
        #1;
        lut_result = lv_pipe[LAT-1] ? lut_f(lval_pipe[LAT-1]) : {$urandom, $urandom};
    end

    // Transaction-level reference model
    typedef struct {
        int          due;
        int          id;
        bit          sat;
        logic [63:0] op;
    } pend_t;

    pend_t       pend[$];
    bit [N-1:0]  m_busy;
    int          m_ptr;
    logic        m_lut_valid;
    logic [63:0] m_lut_value;
    logic [N-1:0] m_resp_valid;
    logic [63:0] m_resp_value;
    logic        m_resp_sat;
    logic        m_idle;
    int          m_sat_count;
    int          cyc = 0;

    always @(negedge clk) begin : model
        int          w;
        logic [63:0] op;
        logic [63:0] cv;
        bit          s;
        logic [N-1:0] exp_ready;
        if (!rst_n) begin
            m_busy = '0; m_ptr = 0; m_lut_valid = 1'b0; m_lut_value = '0;
            m_resp_valid = '0; m_resp_value = '0; m_resp_sat = 1'b0;
            m_idle = 1'b1; m_sat_count = 0;
            pend.delete();
        end
        check("m_lut_valid",  64'(lut_valid),  64'(m_lut_valid));
        check("m_lut_value",  lut_value,       m_lut_value);
        check("m_resp_valid", 64'(resp_valid), 64'(m_resp_valid));
        check("m_resp_value", resp_value,      m_resp_value);
        check("m_resp_sat",   64'(resp_sat),   64'(m_resp_sat));
        check("m_idle",       64'(idle),       64'(m_idle));
        check("m_sat_count",  64'(sat_count),  64'(m_sat_count));
        w = -1;
        if (rst_n && en) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % N] && !m_busy[(m_ptr + k) % N])
                    w = (m_ptr + k) % N;
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        check("m_req_ready", 64'(req_ready), 64'(exp_ready));
        if (rst_n) begin
            m_resp_valid = '0;
            for (int p = pend.size() - 1; p >= 0; p--) begin
                if (pend[p].due == cyc + 1) begin
                    m_resp_valid[pend[p].id] = 1'b1;
                    m_resp_value = lut_f(pend[p].op);
                    m_resp_sat   = pend[p].sat;
                    m_busy[pend[p].id] = 1'b0;
                    pend.delete(p);
                end
            end
            if (w >= 0) begin
                op = req_value[64*w +: 64];
                cv = op; s = 1'b0;
                if ($signed(op) > $signed(64'h0000_0001_0000_0000)) begin
                    cv = 64'h0000_0001_0000_0000; s = 1'b1;
                end else if ($signed(op) < $signed(64'hFFFF_FFFF_0000_0000)) begin
                    cv = 64'hFFFF_FFFF_0000_0000; s = 1'b1;
                end
                m_busy[w]   = 1'b1;
                m_ptr       = (w + 1) % N;
                m_lut_valid = 1'b1;
                m_lut_value = cv;
                if (s && m_sat_count < 65535) m_sat_count++;
                pend.push_back('{due: cyc + LAT + 2, id: w, sat: s, op: cv});
            end else begin
                m_lut_valid = 1'b0;
            end
            m_idle = (m_busy == '0);
        end
        cyc++;
    end

    task automatic issue_one(input int idx, input logic [63:0] v, input logic [63:0] exp_lut);
        set_req(idx, v);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        check("one_ready", 64'(req_ready[idx]), 64'd1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("one_lut_value", lut_value, exp_lut);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req_valid = '0; req_value = '0; lut_result = '0;
        @(negedge clk);
        check("rst_idle",      64'(idle),      64'd1);
        check("rst_lut_valid", 64'(lut_valid), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        tick();
        rst_n = 1'b1; en = 1'b1;

        // Single requester, zero operand
        set_req(0, 64'h0);
        req_valid = 4'b0001;
        @(negedge clk);
        check("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1_lut_valid", 64'(lut_valid), 64'd1);
        check("t1_lut_value", lut_value, 64'h0);
        check("t1_busy_idle", 64'(idle), 64'd0);
        tick();
        tick();
        @(negedge clk);
        check("t1_resp_valid", 64'(resp_valid), 64'h1);
        check("t1_resp_value", resp_value, 64'h0000_1234_5678_9abc);
        check("t1_resp_sat",   64'(resp_sat), 64'd0);
        check("t1_idle",       64'(idle), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // All four requesters streaming
        set_req(0, 64'h0000_0000_4000_0000);
        set_req(1, 64'h0000_0000_8000_0000);
        set_req(2, 64'hFFFF_FFFF_C000_0000);
        set_req(3, 64'hFFFF_FFFF_8000_0000);
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_grant", 64'(req_ready), 64'(1) << i);
            if (i == 3) check("t2_resp0", 64'(resp_valid), 64'h1);
            tick();
        end
        @(negedge clk);
        check("t2_wrap", 64'(req_ready), 64'h1);
        repeat (8) tick();
        req_valid = '0;
        repeat (6) tick();

        // Clamping and exact boundary
        issue_one(1, 64'h0000_0003_0000_0000, 64'h0000_0001_0000_0000);
        issue_one(2, 64'hFFFF_FFF0_0000_0000, 64'hFFFF_FFFF_0000_0000);
        issue_one(0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000);
        repeat (4) tick();
        @(negedge clk);
        check("t3_sat_count", 64'(sat_count), 64'd2);

        // Enable dropped with two lookups in flight
        tick();
        req_valid = 4'b0011;
        @(negedge clk);
        check("t4_first", 64'(req_ready), 64'h2);
        tick();
        @(negedge clk);
        check("t4_second", 64'(req_ready), 64'h1);
        tick();
        en = 1'b0;
        @(negedge clk);
        check("t4_no_ready", 64'(req_ready), 64'h0);
        check("t4_busy", 64'(idle), 64'd0);
        repeat (4) tick();
        @(negedge clk);
        check("t4_idle", 64'(idle), 64'd1);
        check("t4_still_no_ready", 64'(req_ready), 64'h0);
        tick();
        en = 1'b1;
        @(negedge clk);
        check("t4_resume", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        repeat (5) tick();

        // Reset with lookups in flight
        req_valid = 4'b0111;
        repeat (3) tick();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("t5_lut_valid",  64'(lut_valid),  64'd0);
        check("t5_resp_valid", 64'(resp_valid), 64'd0);
        check("t5_resp_value", resp_value,      64'd0);
        check("t5_idle",       64'(idle),       64'd1);
        check("t5_sat_count",  64'(sat_count),  64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("t5_no_resp", 64'(resp_valid), 64'd0);
        tick();

        // Saturating clamp counter
        for (int i = 0; i < N; i++) set_req(i, 64'h0000_0005_0000_0000);
        req_valid = 4'b1111;
        repeat (70010) tick();
        req_valid = '0;
        repeat (6) tick();
        @(negedge clk);
        check("t6_sat_hold", 64'(sat_count), 64'h0000_0000_0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
